irq_ctrl: RTL and testbench

External interrupt controller that feeds the `eip`/`eip_reply` pair of the machine-mode privilege unit. It collects single-cycle `irq` pulses from peripherals (UART, GPIO, SD, ...) into pending bits and gates them with a software enable mask. It then raises `eip` toward the CPU side and holds it until the privilege unit replies. A claim/complete register pair lets the trap handler identify and retire the source.

---
 rtl/irq_ctrl.sv | 133 +++++++++++++
 tb/tb_irq_ctrl.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/irq_ctrl.sv
// External interrupt controller: latches peripheral irq pulses into pending bits,
// masks them with ENABLE and runs the eip/eip_reply handshake plus claim/complete.
module irq_ctrl #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [2:0]   a,
  input  logic [31:0]  d,
  input  logic         we,
  output logic [31:0]  spo,
  input  logic [N-1:0] irq,
  output logic         eip,
  input  logic         eip_reply
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ASSERT  = 2'd1,
    CLAIMED = 2'd2
  } state_t;

  localparam logic [5:0] NUM_SRC = 6'(N);

  state_t      state_r, state_s;
  logic        eip_r, eip_s;
  logic [4:0]  claim_id_r, claim_id_s;
  logic [N-1:0] pending_r, enable_r;
  logic [N-1:0] active_s, clr_s;
  logic [4:0]  best_s;
  logic        complete_s, complete_own_s;

  assign active_s = pending_r & enable_r;
  // A COMPLETE write only counts when it names an existing source.
  assign complete_s     = we && (a == 3'd3) && ({1'b0, d[4:0]} < NUM_SRC);
  assign complete_own_s = complete_s && (d[4:0] == claim_id_r);

  // Decode the completed source into a clear mask and pick the lowest active index.
  always_comb begin
    clr_s  = '0;
    best_s = 5'd0;
    for (int i = 0; i < N; i++) begin
      if (complete_s && (d[4:0] == 5'(i))) begin
        clr_s[i] = 1'b1;
      end else begin
        clr_s[i] = 1'b0;
      end
    end
    for (int i = N - 1; i >= 0; i--) begin
      if (active_s[i]) begin
        best_s = 5'(i);
      end else begin
        best_s = best_s;
      end
    end
  end

  // Handshake state machine next-state and eip/claim decisions.
  always_comb begin
    state_s    = state_r;
    eip_s      = 1'b0;
    claim_id_s = claim_id_r;
    case (state_r)
      IDLE: begin
        if (active_s != '0) begin
          state_s = ASSERT;
          eip_s   = 1'b1;
        end else begin
          state_s = IDLE;
        end
      end
      ASSERT: begin
        eip_s = 1'b1;
        if (eip_reply) begin
          eip_s = 1'b0;
          if (active_s != '0) begin
            claim_id_s = best_s;
            state_s    = CLAIMED;
          end else begin
            state_s = IDLE;
          end
        end else begin
          state_s = ASSERT;
        end
      end
      CLAIMED: begin
        if (complete_own_s) begin
          state_s = IDLE;
        end else begin
          state_s = CLAIMED;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // State, handshake and software-visible registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= IDLE;
      eip_r      <= 1'b0;
      claim_id_r <= 5'd0;
      pending_r  <= '0;
      enable_r   <= '0;
    end else begin
      state_r    <= state_s;
      eip_r      <= eip_s;
      claim_id_r <= claim_id_s;
      pending_r  <= (pending_r & ~clr_s) | irq;
      if (we && (a == 3'd1)) begin
        enable_r <= d[N-1:0];
      end else begin
        enable_r <= enable_r;
      end
    end
  end

  assign eip = eip_r;

  // Side-effect-free register read mux.
  always_comb begin
    spo = 32'd0;
    case (a)
      3'd0:    spo = {{(32-N){1'b0}}, pending_r};
      3'd1:    spo = {{(32-N){1'b0}}, enable_r};
      3'd2:    spo = {(state_r == CLAIMED), 26'd0, claim_id_r};
      default: spo = 32'd0;
    endcase
  end

endmodule

// File: tb/tb_irq_ctrl.sv
// Directed self-checking bench for irq_ctrl: handshake, priority, masking,
// set-over-clear collision, address boundaries and reset mid-handshake.
module tb_irq_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [2:0]  a = 3'd0;
  logic [31:0] d = 32'd0;
  logic        we = 1'b0;
  logic [31:0] spo;
  logic [3:0]  irq = 4'd0;
  logic        eip;
  logic        eip_reply = 1'b0;

  int tests_run = 0;
  int tests_failed = 0;

  irq_ctrl #(.N(4)) dut (
    .clk(clk), .rst(rst), .a(a), .d(d), .we(we), .spo(spo),
    .irq(irq), .eip(eip), .eip_reply(eip_reply)
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [2:0] addr, input logic [31:0] data);
    a = addr; d = data; we = 1'b1;
    cyc();
    we = 1'b0; d = 32'd0;
  endtask

  task automatic reply();
    eip_reply = 1'b1;
    cyc();
    eip_reply = 1'b0;
  endtask

  task automatic pulse(input logic [3:0] v);
    irq = v;
    cyc();
    irq = 4'd0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    cyc(); cyc();
    rst = 1'b0;
    tests_run++;
    if (eip !== 1'b0) begin tests_failed++; $display("FAIL reset_eip got %b want 0", eip); end
    a = 3'd0; #1; tests_run++;
    if (spo !== 32'd0) begin tests_failed++; $display("FAIL reset_pending got %h want 0", spo); end
    a = 3'd1; #1; tests_run++;
    if (spo !== 32'd0) begin tests_failed++; $display("FAIL reset_enable got %h want 0", spo); end
    a = 3'd2; #1; tests_run++;
    if (spo !== 32'd0) begin tests_failed++; $display("FAIL reset_claim got %h want 0", spo); end
  endtask

  task automatic test_basic();
    wr(3'd1, 32'h1);
    for (int i = 0; i < 5; i++) cyc();
    pulse(4'b0001);
    a = 3'd0; #1; tests_run++;
    if (spo !== 32'h1) begin tests_failed++; $display("FAIL basic_pending got %h want 1", spo); end
    tests_run++;
    if (eip !== 1'b0) begin tests_failed++; $display("FAIL basic_eip_early got %b want 0", eip); end
    cyc(); tests_run++;
    if (eip !== 1'b1) begin tests_failed++; $display("FAIL basic_eip_rise got %b want 1", eip); end
    cyc(); cyc(); cyc(); tests_run++;
    if (eip !== 1'b1) begin tests_failed++; $display("FAIL basic_eip_hold got %b want 1", eip); end
    reply(); tests_run++;
    if (eip !== 1'b0) begin tests_failed++; $display("FAIL basic_eip_drop got %b want 0", eip); end
    a = 3'd2; #1; tests_run++;
    if (spo !== 32'h8000_0000) begin tests_failed++; $display("FAIL basic_claim got %h want 80000000", spo); end
    wr(3'd3, 32'd0);
    a = 3'd0; #1; tests_run++;
    if (spo !== 32'd0) begin tests_failed++; $display("FAIL basic_cleared got %h want 0", spo); end
    a = 3'd2; #1; tests_run++;
    if (spo !== 32'd0) begin tests_failed++; $display("FAIL basic_claim_idle got %h want 0", spo); end
    cyc(); cyc(); tests_run++;
    if (eip !== 1'b0) begin tests_failed++; $display("FAIL basic_eip_stay got %b want 0", eip); end
  endtask

  task automatic test_priority();
    wr(3'd1, 32'hF);
    pulse(4'b1010);
    cyc();
    reply();
    a = 3'd2; #1; tests_run++;
    if (spo !== 32'h8000_0001) begin tests_failed++; $display("FAIL prio_claim1 got %h want 80000001", spo); end
    wr(3'd3, 32'd1); tests_run++;
    if (eip !== 1'b0) begin tests_failed++; $display("FAIL prio_gap got %b want 0", eip); end
    cyc(); tests_run++;
    if (eip !== 1'b1) begin tests_failed++; $display("FAIL prio_rerise got %b want 1", eip); end
    reply();
    a = 3'd2; #1; tests_run++;
    if (spo !== 32'h8000_0003) begin tests_failed++; $display("FAIL prio_claim3 got %h want 80000003", spo); end
    wr(3'd3, 32'd3);
    cyc(); tests_run++;
    if (eip !== 1'b0) begin tests_failed++; $display("FAIL prio_done got %b want 0", eip); end
  endtask

  task automatic test_masked_and_disable();
    wr(3'd1, 32'h0);
    pulse(4'b0100);
    a = 3'd0; #1; tests_run++;
    if (spo !== 32'h4) begin tests_failed++; $display("FAIL mask_pending got %h want 4", spo); end
    cyc(); cyc(); tests_run++;
    if (eip !== 1'b0) begin tests_failed++; $display("FAIL mask_eip got %b want 0", eip); end
    wr(3'd1, 32'h4); tests_run++;
    if (eip !== 1'b0) begin tests_failed++; $display("FAIL mask_en_edge got %b want 0", eip); end
    cyc(); tests_run++;
    if (eip !== 1'b1) begin tests_failed++; $display("FAIL mask_en_rise got %b want 1", eip); end
    wr(3'd1, 32'h0); tests_run++;
    if (eip !== 1'b1) begin tests_failed++; $display("FAIL dis_hold got %b want 1", eip); end
    reply(); tests_run++;
    if (eip !== 1'b0) begin tests_failed++; $display("FAIL dis_drop got %b want 0", eip); end
    a = 3'd2; #1; tests_run++;
    if (spo[31] !== 1'b0) begin tests_failed++; $display("FAIL dis_claimed got %b want 0", spo[31]); end
    a = 3'd0; #1; tests_run++;
    if (spo !== 32'h4) begin tests_failed++; $display("FAIL dis_pending got %h want 4", spo); end
    cyc(); tests_run++;
    if (eip !== 1'b0) begin tests_failed++; $display("FAIL dis_idle got %b want 0", eip); end
    wr(3'd3, 32'd2);
  endtask

  task automatic test_boundary();
    pulse(4'b0001);
    wr(3'd3, 32'd4);
    a = 3'd0; #1; tests_run++;
    if (spo !== 32'h1) begin tests_failed++; $display("FAIL bnd_k_ge_n got %h want 1", spo); end
    wr(3'd5, 32'hFFFF_FFFF);
    a = 3'd5; #1; tests_run++;
    if (spo !== 32'd0) begin tests_failed++; $display("FAIL bnd_addr5 got %h want 0", spo); end
    a = 3'd3; #1; tests_run++;
    if (spo !== 32'd0) begin tests_failed++; $display("FAIL bnd_complete_rd got %h want 0", spo); end
    wr(3'd1, 32'hFFFF_FFF0);
    a = 3'd1; #1; tests_run++;
    if (spo !== 32'd0) begin tests_failed++; $display("FAIL bnd_enable_upper got %h want 0", spo); end
    reply(); tests_run++;
    if (eip !== 1'b0) begin tests_failed++; $display("FAIL bnd_idle_reply got %b want 0", eip); end
    a = 3'd2; #1; tests_run++;
    if (spo[31] !== 1'b0) begin tests_failed++; $display("FAIL bnd_idle_claim got %b want 0", spo[31]); end
    wr(3'd3, 32'd0);
  endtask

  task automatic test_back_to_back();
    wr(3'd1, 32'h1);
    pulse(4'b0001);
    cyc();
    reply();
    irq = 4'b0001;
    wr(3'd3, 32'd0);
    irq = 4'd0;
    a = 3'd0; #1; tests_run++;
    if (spo !== 32'h1) begin tests_failed++; $display("FAIL b2b_set_wins got %h want 1", spo); end
    a = 3'd2; #1; tests_run++;
    if (spo[31] !== 1'b0) begin tests_failed++; $display("FAIL b2b_idle got %b want 0", spo[31]); end
    tests_run++;
    if (eip !== 1'b0) begin tests_failed++; $display("FAIL b2b_gap got %b want 0", eip); end
    cyc(); tests_run++;
    if (eip !== 1'b1) begin tests_failed++; $display("FAIL b2b_rerise got %b want 1", eip); end
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    tests_run++;
    if (eip !== 1'b0) begin tests_failed++; $display("FAIL rst_eip got %b want 0", eip); end
    a = 3'd0; #1; tests_run++;
    if (spo !== 32'd0) begin tests_failed++; $display("FAIL rst_pending got %h want 0", spo); end
    a = 3'd1; #1; tests_run++;
    if (spo !== 32'd0) begin tests_failed++; $display("FAIL rst_enable got %h want 0", spo); end
    a = 3'd2; #1; tests_run++;
    if (spo !== 32'd0) begin tests_failed++; $display("FAIL rst_claim got %h want 0", spo); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_priority();
    test_masked_and_disable();
    test_boundary();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
